// File: rtl/simple_0.sv
// Registered single-digit BCD cell: increment with carry (C=0) or nines-complement (C=1).
// Optional sticky invalid-input flag ERR when SIMPLE0_ERR_FLAG_EN is defined.
module simple_0 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic       C,
  output logic [3:0] B,
  output logic       D
`ifdef SIMPLE0_ERR_FLAG_EN
  ,
  output logic       ERR
`endif
);

  logic       a_valid;
  logic [3:0] b_nxt;
  logic       d_nxt;

  assign a_valid = (A <= 4'd9);

  // Stays in 4 bits: the A=9 increment wraps explicitly instead of producing 10.
  always_comb begin
    b_nxt = '1;
    d_nxt = 1'b0;
    if (a_valid) begin
      if (C) begin
        b_nxt = 4'd9 - A;
      end else if (A == 4'd9) begin
        b_nxt = '0;
        d_nxt = 1'b1;
      end else begin
        b_nxt = A + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      B <= '0;
      D <= 1'b0;
    end else begin
      B <= b_nxt;
      D <= d_nxt;
    end
  end

`ifdef SIMPLE0_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ERR <= 1'b0;
    end else if (!a_valid) begin
      ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simple_0.sv
// Self-checking bench for simple_0: directed plan followed by randomized steps
// checked against an arithmetic reference model.
module tb_simple_0;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       C;
  logic       D;
`ifdef SIMPLE0_ERR_FLAG_EN
  logic       ERR;
  logic       exp_err;
`endif

  logic [3:0] exp_b;
  logic       exp_d;
  int unsigned chk_cnt;
  int unsigned pass_cnt;

  simple_0 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D)
`ifdef SIMPLE0_ERR_FLAG_EN
    ,
    .ERR   (ERR)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: decimal arithmetic on plain integers.
  function automatic void model(input int a, input bit c, output logic [3:0] b, output logic d);
    int r;
    d = 1'b0;
    if (a > 9) begin
      r = 15;
    end else if (c) begin
      r = 9 - a;
    end else begin
      r = (a + 1) % 10;
      d = (a == 9);
    end
    b = 4'(r);
  endfunction

  task automatic check(input string tag);
    chk_cnt++;
    assert (B === exp_b) pass_cnt++;
    else $error("FAIL %s B: got %0d expected %0d (A=%0d C=%0d rst_n=%0d)", tag, B, exp_b, A, C, rst_n);
    chk_cnt++;
    assert (D === exp_d) pass_cnt++;
    else $error("FAIL %s D: got %0b expected %0b (A=%0d C=%0d rst_n=%0d)", tag, D, exp_d, A, C, rst_n);
`ifdef SIMPLE0_ERR_FLAG_EN
    chk_cnt++;
    assert (ERR === exp_err) pass_cnt++;
    else $error("FAIL %s ERR: got %0b expected %0b (A=%0d)", tag, ERR, exp_err, A);
`endif
  endtask

  // Drive one set of inputs, take one rising edge, then compare.
  task automatic step(input int a, input bit c, input bit r, input string tag);
    A     = 4'(a);
    C     = c;
    rst_n = r;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_b = 4'd0;
      exp_d = 1'b0;
`ifdef SIMPLE0_ERR_FLAG_EN
      exp_err = 1'b0;
`endif
    end else begin
      model(a, c, exp_b, exp_d);
`ifdef SIMPLE0_ERR_FLAG_EN
      if (a > 9) exp_err = 1'b1;
`endif
    end
    check(tag);
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    exp_b    = '0;
    exp_d    = 1'b0;
`ifdef SIMPLE0_ERR_FLAG_EN
    exp_err  = 1'b0;
`endif
    A     = 4'd9;
    C     = 1'b0;
    rst_n = 1'b0;
    #2;

    step(9, 0, 0, "reset0");
    step(9, 0, 0, "reset1");
    step(9, 0, 1, "rst_release");

    for (int i = 9; i >= 0; i--) step(i, 0, 1, "inc_sweep");

    // Outputs must hold mid-cycle until the next edge.
    A = 4'd5;
    #3;
    check("hold");

    step(0, 1, 1, "cmp_0");
    step(3, 1, 1, "cmp_3");
    step(9, 1, 1, "cmp_9");

    step(9, 0, 1, "mode_inc");
    step(9, 1, 1, "mode_cmp");

    step(12, 0, 1, "invalid_12");
    step(2, 0, 1, "after_invalid");
    step(15, 1, 1, "invalid_15");
    step(4, 1, 1, "after_invalid_cmp");

    step(9, 0, 1, "pre_midreset");
    step(9, 0, 0, "midreset");
    step(9, 0, 1, "post_midreset");

    for (int n = 0; n < 300; n++) begin
      step(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 24) != 0), "random");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/simple_0.md
Name: simple_0

Overview:
- Single-digit registered BCD unit.
- Takes a 4-bit BCD digit A and a mode bit C, and produces a 4-bit BCD result B and a flag D, registered on the clock.
- Mode C=0 is a BCD increment with carry-out on D. Mode C=1 is a nines-complement with D held low.
- Used as a leaf digit cell in decimal counter and subtractor chains: D of one cell drives the increment enable of the next stage.

Parameters:
- None. Digit width is fixed at 4 bits (BCD).

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  reset, synchronous, active-low
- A      input   4  BCD operand digit; valid range 0..9
- B      output  4  registered result digit
- C      input   1  mode: 0 = increment, 1 = nines-complement
- D      output  1  registered carry-out / flag

Behaviour:
- One clock. Reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset (rst_n=0 at a rising edge):
  - B=4'd0, D=0.
  - Reset overrides A and C in the same cycle.
- Latency:
  - Outputs are registered. A and C sampled at edge N appear on B and D after edge N.
  - New operands are accepted every cycle; no handshake.
  - B and D hold their value until the next edge.
- Mode C=0, increment:
  - A in 0..8: B=A+1, D=0.
  - A=9: B=0, D=1 (decimal wrap-around, carry-out).
- Mode C=1, nines-complement:
  - A in 0..9: B=9-A, D=0.
- Invalid input (A in 10..15), either mode:
  - B=4'hF, D=0.
  - No state is corrupted; the next valid input produces a normal result.
- Arithmetic:
  - Computed in 4 bits, never exceeds 9 for valid input.
  - No intermediate 5-bit overflow escapes to B.
- Mode changes take effect on the same edge as A; there is no mode pipeline.
- rst_n deasserted with A/C stable: the first post-reset edge produces the normal result for that A/C.

Optional Feature:
- Macro: SIMPLE0_ERR_FLAG_EN.
- When defined:
  - Adds output port ERR (1 bit, registered).
  - ERR is set to 1 on the edge where an invalid A (10..15) is sampled.
  - ERR is sticky: it stays 1 until reset.
  - Reset clears ERR to 0.
  - B and D behaviour is unchanged.
- When not defined:
  - No ERR port.
  - Invalid input is reported only by B=4'hF.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with A=9, C=0 -> B=0, D=0. Release rst_n -> next edge B=0, D=1.
- Increment sweep: C=0, A stepped 9,8,7,...,0 one per 10 time units (at least one edge each) -> B follows 0,9,8,...,1. D=1 only for A=9, otherwise 0.
- Complement: C=1, A=0 -> B=9, D=0. A=3 -> B=6. A=9 -> B=0, D=0.
- Mode switch with A held at 9: C=0 -> B=0, D=1. Next edge C=1 -> B=0, D=0.
- Invalid input: A=12, C=0 -> B=4'hF, D=0. Then A=2 -> B=3. With SIMPLE0_ERR_FLAG_EN, ERR=1 from the A=12 edge until the next reset.
- Mid-operation reset: A=9, C=0 with D=1. Assert rst_n=0 for one edge -> B=0, D=0 on that edge.
